// File: rtl/layer_sequencer_pkg.sv
// Shared types for layer_sequencer: packed layer descriptor, FSM state encoding, error causes
// and the descriptor sanity check.
package layer_sequencer_pkg;

   localparam int unsigned DESC_W = 61;

   typedef struct packed {
      logic [15:0] img_w;
      logic [15:0] img_h;
      logic [3:0]  kernel_r;
      logic [15:0] num_in_ch;
      logic        pool;
      logic        bias;
      logic        relu;
      logic        quant;
      logic [4:0]  shift;
   } layer_desc_t;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StIssue,
      StWait,
      StNext,
      StFinish,
      StDrain,
      StErr
   } seq_state_t;

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_BAD_DESC = 2'd1;
   localparam logic [1:0] ERR_ABORT    = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

   // A kernel must be non-empty and fit inside the image, and there must be input channels.
   function automatic logic desc_is_bad(layer_desc_t d);
      return (d.kernel_r == 4'd0) || ({12'd0, d.kernel_r} > d.img_w) ||
             ({12'd0, d.kernel_r} > d.img_h) || (d.num_in_ch == 16'd0);
   endfunction

endpackage

// File: rtl/layer_desc_regfile.sv
// Descriptor table: one write port (dropped while the sequencer is busy or the slot is out of
// range) and one asynchronous read port. Contents are not reset.
module layer_desc_regfile
   import layer_sequencer_pkg::*;
#(
   parameter int unsigned MAX_LAYERS  = 8,
   parameter int unsigned LAYER_IDX_W = $clog2(MAX_LAYERS)
) (
   input  logic                   i_clk,
   input  logic                   i_busy,
   input  logic                   i_wr_en,
   input  logic [LAYER_IDX_W-1:0] i_wr_idx,
   input  logic [DESC_W-1:0]      i_wr_data,
   input  logic [LAYER_IDX_W-1:0] i_rd_idx,
   output logic [DESC_W-1:0]      o_rd_data
);

   logic [DESC_W-1:0] r_mem [MAX_LAYERS];
   logic              w_wr_ok;

   assign w_wr_ok = i_wr_en && !i_busy &&
                    ({1'b0, i_wr_idx} < (LAYER_IDX_W+1)'(MAX_LAYERS));

   always_ff @(posedge i_clk) begin
      if (w_wr_ok) begin
         r_mem[i_wr_idx] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/layer_sequencer.sv
// Walks the descriptor table, configuring and starting systolic_wrapper once per layer.
// Optional per-layer watchdog is enabled by defining LAYER_TIMEOUT_EN.
module layer_sequencer
   import layer_sequencer_pkg::*;
#(
   parameter int unsigned MAX_LAYERS     = 8,
   parameter int unsigned LAYER_IDX_W    = $clog2(MAX_LAYERS),
   parameter int unsigned PTR_WIDTH      = 32
`ifdef LAYER_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYCLES = 2**20
`endif
) (
   input  logic                   clk_i,
   input  logic                   rst_sync_n_i,
   input  logic                   start_i,
   input  logic                   abort_i,
   input  logic [LAYER_IDX_W:0]   num_layers_i,
   input  logic                   desc_wr_en_i,
   input  logic [LAYER_IDX_W-1:0] desc_wr_idx_i,
   input  logic [DESC_W-1:0]      desc_wr_data_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   err_o,
   output logic [1:0]             err_code_o,
   output logic [LAYER_IDX_W-1:0] cur_layer_o,
   output logic                   sa_start_o,
   input  logic                   sa_busy_i,
   input  logic                   sa_done_i,
   output logic [PTR_WIDTH-1:0]   cfg_img_w_o,
   output logic [PTR_WIDTH-1:0]   cfg_img_h_o,
   output logic [3:0]             cfg_kernel_r_o,
   output logic [15:0]            cfg_num_input_channels_o,
   output logic                   do_pooling_o,
   output logic                   has_bias_o,
   output logic                   do_relu_o,
   output logic                   has_quant_o,
   output logic [4:0]             quant_shift_o
);

   seq_state_t             r_state, w_state_nxt;
   logic [LAYER_IDX_W:0]   r_num_layers, w_num_layers_nxt;
   logic [LAYER_IDX_W-1:0] r_cur_layer, w_cur_layer_nxt;
   layer_desc_t            r_cfg, w_cfg_nxt, w_rd_desc;
   logic                   r_err, w_err_nxt;
   logic [1:0]             r_err_code, w_err_code_nxt;
   logic [1:0]             r_pend_code, w_pend_code_nxt;
   logic [DESC_W-1:0]      w_rd_data;
   logic                   w_last_layer;

   layer_desc_regfile #(
      .MAX_LAYERS  (MAX_LAYERS),
      .LAYER_IDX_W (LAYER_IDX_W)
   ) u_regfile (
      .i_clk     (clk_i),
      .i_busy    (busy_o),
      .i_wr_en   (desc_wr_en_i),
      .i_wr_idx  (desc_wr_idx_i),
      .i_wr_data (desc_wr_data_i),
      .i_rd_idx  (r_cur_layer),
      .o_rd_data (w_rd_data)
   );

   assign w_rd_desc    = layer_desc_t'(w_rd_data);
   assign w_last_layer = (({1'b0, r_cur_layer} + (LAYER_IDX_W+1)'(1)) == r_num_layers);

`ifdef LAYER_TIMEOUT_EN
   logic [20:0] r_tmo_cnt;
   logic        w_tmo_hit;

   always_ff @(posedge clk_i) begin
      if (!rst_sync_n_i) begin
         r_tmo_cnt <= '0;
      end else if (r_state == StIssue) begin
         r_tmo_cnt <= '0;
      end else if (r_state == StWait) begin
         r_tmo_cnt <= r_tmo_cnt + 21'd1;
      end
   end

   // Fires on the TIMEOUT_CYCLES-th cycle spent in WAIT.
   assign w_tmo_hit = (r_tmo_cnt == 21'(TIMEOUT_CYCLES - 1));
`endif

   always_comb begin
      w_state_nxt      = r_state;
      w_num_layers_nxt = r_num_layers;
      w_cur_layer_nxt  = r_cur_layer;
      w_cfg_nxt        = r_cfg;
      w_err_nxt        = r_err;
      w_err_code_nxt   = r_err_code;
      w_pend_code_nxt  = r_pend_code;
      unique case (r_state)
         StIdle: begin
            if (start_i && !abort_i) begin
               w_num_layers_nxt = num_layers_i;
               w_cur_layer_nxt  = '0;
               w_err_nxt        = 1'b0;
               w_err_code_nxt   = ERR_NONE;
               w_state_nxt      = (num_layers_i == '0) ? StFinish : StLoad;
            end
         end
         StLoad: begin
            w_cfg_nxt = w_rd_desc;
            if (abort_i) begin
               w_state_nxt    = StErr;
               w_err_nxt      = 1'b1;
               w_err_code_nxt = ERR_ABORT;
            end else if (desc_is_bad(w_rd_desc)) begin
               w_state_nxt    = StErr;
               w_err_nxt      = 1'b1;
               w_err_code_nxt = ERR_BAD_DESC;
            end else begin
               w_state_nxt = StIssue;
            end
         end
         StIssue: begin
            if (abort_i) begin
               w_state_nxt    = StErr;
               w_err_nxt      = 1'b1;
               w_err_code_nxt = ERR_ABORT;
            end else begin
               w_state_nxt = StWait;
            end
         end
         StWait: begin
            if (abort_i) begin
               w_state_nxt     = StDrain;
               w_pend_code_nxt = ERR_ABORT;
            end else if (sa_done_i) begin
               w_state_nxt = StNext;
            end
`ifdef LAYER_TIMEOUT_EN
            else if (w_tmo_hit) begin
               w_state_nxt     = StDrain;
               w_pend_code_nxt = ERR_TIMEOUT;
            end
`endif
         end
         StNext: begin
            if (abort_i) begin
               w_state_nxt    = StErr;
               w_err_nxt      = 1'b1;
               w_err_code_nxt = ERR_ABORT;
            end else if (w_last_layer) begin
               w_state_nxt = StFinish;
            end else begin
               w_cur_layer_nxt = r_cur_layer + LAYER_IDX_W'(1);
               w_state_nxt     = StLoad;
            end
         end
         StFinish: w_state_nxt = StIdle;
         StDrain: begin
            // The wrapper cannot be aborted; hold off until it has stopped.
            if (sa_done_i || !sa_busy_i) begin
               w_state_nxt    = StErr;
               w_err_nxt      = 1'b1;
               w_err_code_nxt = r_pend_code;
            end
         end
         StErr:   w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_sync_n_i) begin
         r_state      <= StIdle;
         r_num_layers <= '0;
         r_cur_layer  <= '0;
         r_cfg        <= '0;
         r_err        <= 1'b0;
         r_err_code   <= ERR_NONE;
         r_pend_code  <= ERR_NONE;
      end else begin
         r_state      <= w_state_nxt;
         r_num_layers <= w_num_layers_nxt;
         r_cur_layer  <= w_cur_layer_nxt;
         r_cfg        <= w_cfg_nxt;
         r_err        <= w_err_nxt;
         r_err_code   <= w_err_code_nxt;
         r_pend_code  <= w_pend_code_nxt;
      end
   end

   assign busy_o                   = (r_state != StIdle);
   assign done_o                   = (r_state == StFinish);
   assign sa_start_o               = (r_state == StIssue);
   assign err_o                    = r_err;
   assign err_code_o               = r_err_code;
   assign cur_layer_o              = r_cur_layer;
   assign cfg_img_w_o              = PTR_WIDTH'(r_cfg.img_w);
   assign cfg_img_h_o              = PTR_WIDTH'(r_cfg.img_h);
   assign cfg_kernel_r_o           = r_cfg.kernel_r;
   assign cfg_num_input_channels_o = r_cfg.num_in_ch;
   assign do_pooling_o             = r_cfg.pool;
   assign has_bias_o               = r_cfg.bias;
   assign do_relu_o                = r_cfg.relu;
   assign has_quant_o              = r_cfg.quant;
   assign quant_shift_o            = r_cfg.shift;

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer: directed scenarios plus randomized networks checked
// against a descriptor table model and the expected per-layer handshake timeline.
module tb_layer_sequencer;

   localparam int unsigned IdxW = 3;
   localparam int unsigned PtrW = 32;

   logic            clk_i = 1'b0;
   logic            rst_sync_n_i;
   logic            start_i, abort_i;
   logic [IdxW:0]   num_layers_i;
   logic            desc_wr_en_i;
   logic [IdxW-1:0] desc_wr_idx_i;
   logic [60:0]     desc_wr_data_i;
   logic            busy_o, done_o, err_o;
   logic [1:0]      err_code_o;
   logic [IdxW-1:0] cur_layer_o;
   logic            sa_start_o, sa_busy_i, sa_done_i;
   logic [PtrW-1:0] cfg_img_w_o, cfg_img_h_o;
   logic [3:0]      cfg_kernel_r_o;
   logic [15:0]     cfg_num_input_channels_o;
   logic            do_pooling_o, has_bias_o, do_relu_o, has_quant_o;
   logic [4:0]      quant_shift_o;

   int n_checks = 0;
   int n_errors = 0;

   // Reference descriptor table, updated only by writes the bench expects to be accepted.
   int m_w[8], m_h[8], m_k[8], m_c[8], m_pool[8], m_bias[8], m_relu[8], m_quant[8], m_shift[8];

   always #5 clk_i = ~clk_i;

   layer_sequencer #(
      .MAX_LAYERS     (8),
      .LAYER_IDX_W    (IdxW),
      .PTR_WIDTH      (PtrW)
`ifdef LAYER_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES (100)
`endif
   ) dut (
      .clk_i                    (clk_i),
      .rst_sync_n_i             (rst_sync_n_i),
      .start_i                  (start_i),
      .abort_i                  (abort_i),
      .num_layers_i             (num_layers_i),
      .desc_wr_en_i             (desc_wr_en_i),
      .desc_wr_idx_i            (desc_wr_idx_i),
      .desc_wr_data_i           (desc_wr_data_i),
      .busy_o                   (busy_o),
      .done_o                   (done_o),
      .err_o                    (err_o),
      .err_code_o               (err_code_o),
      .cur_layer_o              (cur_layer_o),
      .sa_start_o               (sa_start_o),
      .sa_busy_i                (sa_busy_i),
      .sa_done_i                (sa_done_i),
      .cfg_img_w_o              (cfg_img_w_o),
      .cfg_img_h_o              (cfg_img_h_o),
      .cfg_kernel_r_o           (cfg_kernel_r_o),
      .cfg_num_input_channels_o (cfg_num_input_channels_o),
      .do_pooling_o             (do_pooling_o),
      .has_bias_o               (has_bias_o),
      .do_relu_o                (do_relu_o),
      .has_quant_o              (has_quant_o),
      .quant_shift_o            (quant_shift_o)
   );

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic write_desc(input int idx, input int w, input int h, input int k, input int c,
                             input int pool, input int bias, input int relu, input int quant,
                             input int shift, input bit accept);
      desc_wr_en_i   = 1'b1;
      desc_wr_idx_i  = idx[IdxW-1:0];
      desc_wr_data_i = {w[15:0], h[15:0], k[3:0], c[15:0], pool[0], bias[0], relu[0], quant[0],
                        shift[4:0]};
      tick();
      desc_wr_en_i = 1'b0;
      if (accept) begin
         m_w[idx] = w; m_h[idx] = h; m_k[idx] = k; m_c[idx] = c;
         m_pool[idx] = pool; m_bias[idx] = bias; m_relu[idx] = relu;
         m_quant[idx] = quant; m_shift[idx] = shift;
      end
   endtask

   task automatic random_desc(input int idx, input bit loose);
      int w, h, k, c;
      if (loose) begin
         w = $urandom_range(1, 12); h = $urandom_range(1, 12);
         k = $urandom_range(0, 15); c = $urandom_range(0, 3);
      end else begin
         w = $urandom_range(15, 65535); h = $urandom_range(15, 65535);
         k = $urandom_range(1, 15);     c = $urandom_range(1, 65535);
      end
      write_desc(idx, w, h, k, c, $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 31), 1'b1);
   endtask

   function automatic bit desc_bad(input int l);
      return (m_k[l] == 0) || (m_k[l] > m_w[l]) || (m_k[l] > m_h[l]) || (m_c[l] == 0);
   endfunction

   task automatic check_cfg(input int l);
      check_eq("cfg_img_w", cfg_img_w_o, m_w[l]);
      check_eq("cfg_img_h", cfg_img_h_o, m_h[l]);
      check_eq("cfg_kernel", cfg_kernel_r_o, m_k[l]);
      check_eq("cfg_in_ch", cfg_num_input_channels_o, m_c[l]);
      check_eq("cfg_flags", {do_pooling_o, has_bias_o, do_relu_o, has_quant_o},
               {m_pool[l][0], m_bias[l][0], m_relu[l][0], m_quant[l][0]});
      check_eq("cfg_shift", quant_shift_o, m_shift[l]);
   endtask

   task automatic check_all_zero();
      check_eq("zero_busy", busy_o, 0);
      check_eq("zero_done", done_o, 0);
      check_eq("zero_err", {err_o, err_code_o}, 0);
      check_eq("zero_layer", cur_layer_o, 0);
      check_eq("zero_sa_start", sa_start_o, 0);
      check_eq("zero_cfg", {cfg_img_w_o, cfg_img_h_o, cfg_kernel_r_o, cfg_num_input_channels_o,
               do_pooling_o, has_bias_o, do_relu_o, has_quant_o, quant_shift_o}, 0);
   endtask

   // Start a pass of n layers; the wrapper answers each start after 1..max_delay WAIT cycles.
   // Expected timeline: start -> LOAD -> ISSUE(sa_start); sa_done -> NEXT -> LOAD/FINISH.
   task automatic run_net(input int n, input int max_delay);
      int d;
      start_i      = 1'b1;
      num_layers_i = n[IdxW:0];
      tick();
      start_i = 1'b0;
      if (n == 0) begin
         check_eq("empty_busy", busy_o, 1);
         check_eq("empty_done", done_o, 1);
         check_eq("empty_no_start", sa_start_o, 0);
         tick();
         check_eq("empty_idle", busy_o, 0);
         check_eq("empty_done_pulse", done_o, 0);
         return;
      end
      check_eq("err_cleared", {err_o, err_code_o}, 0);
      for (int l = 0; l < n; l++) begin
         check_eq("load_busy", busy_o, 1);
         check_eq("load_no_start", sa_start_o, 0);
         tick();
         if (desc_bad(l)) begin
            check_eq("bad_err", err_o, 1);
            check_eq("bad_code", err_code_o, 1);
            check_eq("bad_layer", cur_layer_o, l);
            check_eq("bad_no_start", sa_start_o, 0);
            check_eq("bad_busy", busy_o, 1);
            tick();
            check_eq("bad_idle", busy_o, 0);
            check_eq("bad_sticky", {err_o, err_code_o}, 3'b101);
            check_eq("bad_no_done", done_o, 0);
            check_eq("bad_no_start2", sa_start_o, 0);
            return;
         end
         check_eq("issue_start", sa_start_o, 1);
         check_eq("issue_layer", cur_layer_o, l);
         check_cfg(l);
         sa_busy_i = 1'b1;
         d = $urandom_range(1, max_delay);
         repeat (d) begin
            tick();
            check_eq("wait_no_start", sa_start_o, 0);
         end
         check_eq("wait_cfg_hold", cfg_img_w_o, m_w[l]);
         sa_done_i = 1'b1;
         sa_busy_i = 1'b0;
         tick();
         sa_done_i = 1'b0;
         check_eq("next_busy", busy_o, 1);
         check_eq("next_no_start", sa_start_o, 0);
         check_eq("next_no_done", done_o, 0);
         tick();
      end
      check_eq("finish_done", done_o, 1);
      check_eq("finish_busy", busy_o, 1);
      check_eq("finish_err", err_o, 0);
      tick();
      check_eq("idle_busy", busy_o, 0);
      check_eq("idle_done", done_o, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_sync_n_i   = 1'b0;
      start_i        = 1'b0;
      abort_i        = 1'b0;
      num_layers_i   = '0;
      desc_wr_en_i   = 1'b0;
      desc_wr_idx_i  = '0;
      desc_wr_data_i = '0;
      sa_busy_i      = 1'b0;
      sa_done_i      = 1'b0;
      repeat (3) tick();
      check_all_zero();
      rst_sync_n_i = 1'b1;
      tick();

      // LeNet conv1 / conv2
      write_desc(0, 28, 28, 5, 1, 1, 1, 1, 0, 0, 1'b1);
      write_desc(1, 14, 14, 5, 6, 1, 1, 1, 0, 0, 1'b1);
      run_net(2, 4);
      run_net(0, 1);

      // Layer 1 kernel larger than the image
      write_desc(1, 8, 20, 9, 4, 0, 1, 0, 1, 3, 1'b1);
      run_net(2, 3);

      // start and abort together: start is not accepted, so the sticky error survives
      start_i      = 1'b1;
      abort_i      = 1'b1;
      num_layers_i = 4'd1;
      tick();
      start_i = 1'b0;
      abort_i = 1'b0;
      check_eq("sa_abort_idle", busy_o, 0);
      check_eq("sa_abort_err_kept", {err_o, err_code_o}, 3'b101);
      tick();
      check_eq("sa_abort_no_start", sa_start_o, 0);
      rst_sync_n_i = 1'b0;
      tick();
      rst_sync_n_i = 1'b1;
      check_all_zero();

      // Abort during WAIT: drain until the wrapper finishes; writes meanwhile are dropped
      random_desc(0, 1'b0);
      start_i      = 1'b1;
      num_layers_i = 4'd1;
      tick();
      start_i = 1'b0;
      tick();
      check_eq("abort_issue", sa_start_o, 1);
      sa_busy_i = 1'b1;
      tick();
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      check_eq("drain_busy", busy_o, 1);
      check_eq("drain_no_err", err_o, 0);
      write_desc(0, 7, 7, 3, 7, 0, 0, 0, 0, 0, 1'b0);
      repeat (48) tick();
      check_eq("drain_still_busy", busy_o, 1);
      sa_done_i = 1'b1;
      tick();
      sa_done_i = 1'b0;
      sa_busy_i = 1'b0;
      check_eq("abort_err", {err_o, err_code_o}, 3'b110);
      check_eq("abort_err_busy", busy_o, 1);
      check_eq("abort_no_done", done_o, 0);
      tick();
      check_eq("abort_idle", busy_o, 0);
      check_eq("abort_sticky", {err_o, err_code_o}, 3'b110);
      run_net(1, 3);

      // Wrapper that never reports done
      start_i      = 1'b1;
      num_layers_i = 4'd1;
      tick();
      start_i = 1'b0;
      tick();
      sa_busy_i = 1'b1;
`ifdef LAYER_TIMEOUT_EN
      repeat (150) tick();
      check_eq("tmo_drain_busy", busy_o, 1);
      check_eq("tmo_drain_no_err", err_o, 0);
      sa_busy_i = 1'b0;
      tick();
      check_eq("tmo_err", {err_o, err_code_o}, 3'b111);
      tick();
      check_eq("tmo_idle", busy_o, 0);
`else
      repeat (1000) tick();
      check_eq("hang_busy", busy_o, 1);
      check_eq("hang_no_err", err_o, 0);
      check_eq("hang_no_done", done_o, 0);
      abort_i   = 1'b1;
      sa_busy_i = 1'b0;
      tick();
      abort_i = 1'b0;
      check_eq("hang_drain", busy_o, 1);
      tick();
      check_eq("hang_abort_err", {err_o, err_code_o}, 3'b110);
      tick();
      check_eq("hang_idle", busy_o, 0);
`endif

      // Reset in the middle of layer 1's WAIT
      random_desc(0, 1'b0);
      random_desc(1, 1'b0);
      start_i      = 1'b1;
      num_layers_i = 4'd2;
      tick();
      start_i = 1'b0;
      tick();
      sa_busy_i = 1'b1;
      tick();
      sa_done_i = 1'b1;
      sa_busy_i = 1'b0;
      tick();
      sa_done_i = 1'b0;
      tick();
      tick();
      check_eq("rst_run_layer", cur_layer_o, 1);
      check_eq("rst_run_start", sa_start_o, 1);
      sa_busy_i = 1'b1;
      tick();
      rst_sync_n_i = 1'b0;
      tick();
      rst_sync_n_i = 1'b1;
      sa_busy_i    = 1'b0;
      check_all_zero();
      tick();
      check_eq("rst_stays_idle", busy_o, 0);

      // Random networks
      for (int it = 0; it < 25; it++) begin
         bit loose;
         loose = ($urandom_range(0, 3) == 0);
         for (int i = 0; i < 8; i++) random_desc(i, loose);
         run_net($urandom_range(0, 8), 6);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
